// File: rtl/plantard_bprep_if.sv
// Job/result bus of the Plantard b-operand preparation stage.
// Both directions use valid/ready: a beat moves on a rising edge where valid && ready.
interface plantard_bprep_if;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  a_in;
  logic [63:0]  b_in;
  logic [127:0] qinv;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  a_out;
  logic [127:0] bq_out;

  modport master (
    output in_valid, a_in, b_in, qinv, out_ready,
    input  in_ready, out_valid, a_out, bq_out
  );

  modport slave (
    input  in_valid, a_in, b_in, qinv, out_ready,
    output in_ready, out_valid, a_out, bq_out
  );
endinterface

// File: rtl/plantard_bprep.sv
// Digit-serial truncated multiply bq = (b * qinv) mod 2^128, one DIGIT x 128 product per cycle.
// Handshake: a job is taken on an edge with in_valid && in_ready; the result is held until out_valid && out_ready.
module plantard_bprep #(
  parameter int DIGIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  plantard_bprep_if.slave  bus,
  output logic [1:0]       dbg_state
);

  generate
    if (!(DIGIT == 8 || DIGIT == 16 || DIGIT == 32 || DIGIT == 64)) begin : g_bad_digit
      $error("plantard_bprep: DIGIT must be 8, 16, 32 or 64");
    end
  endgenerate

  localparam int NDIG = 64 / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [63:0]         a_q;
  logic [63:0]         b_q;
  logic [127:0]        q_q;
  logic [127:0]        acc;

  logic [6:0]          shamt;
  logic [DIGIT-1:0]    digit;
  logic [DIGIT+127:0]  pp_full;
  logic [DIGIT+127:0]  pp_sh;
  logic [127:0]        acc_next;

  assign dbg_state = state;

  // Full-width partial product, shifted into place and truncated; carries past bit 127 are dropped.
  always_comb begin
    shamt    = 7'(cnt) * 7'(DIGIT);
    digit    = b_q[shamt[5:0] +: DIGIT];
    pp_full  = {128'b0, digit} * {{DIGIT{1'b0}}, q_q};
    pp_sh    = pp_full << shamt;
    acc_next = acc + pp_sh[127:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      a_q           <= '0;
      b_q           <= '0;
      q_q           <= '0;
      acc           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.a_out     <= '0;
      bus.bq_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q          <= bus.a_in;
            b_q          <= bus.b_in;
            q_q          <= bus.qinv;
            acc          <= '0;
            cnt          <= '0;
            bus.in_ready <= 1'b0;
            state        <= MUL;
          end
        end
        MUL: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(NDIG - 1)) begin
            bus.bq_out    <= acc_next;
            bus.a_out     <= a_q;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          // in_ready rises only after the drain edge, so no accept in the same cycle.
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plantard_bprep.sv
// Directed bench for plantard_bprep: reset, latency, wrap-around across DIGIT widths,
// backpressure, mid-job reset, edge operands and a short randomised scoreboard run.
module tb_plantard_bprep;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  plantard_bprep_if bus ();
  plantard_bprep_if bus8 ();
  plantard_bprep_if bus32 ();
  plantard_bprep_if bus64 ();

  logic [1:0] st16, st8, st32, st64;

  plantard_bprep #(.DIGIT(16)) dut16 (.clk(clk), .rst(rst), .bus(bus.slave),   .dbg_state(st16));
  plantard_bprep #(.DIGIT(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave),  .dbg_state(st8));
  plantard_bprep #(.DIGIT(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave), .dbg_state(st32));
  plantard_bprep #(.DIGIT(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64.slave), .dbg_state(st64));

  // Secondary instances share one stimulus set.
  logic         x_valid;
  logic [63:0]  x_a;
  logic [63:0]  x_b;
  logic [127:0] x_q;
  logic         x_oready;

  assign bus8.in_valid   = x_valid;  assign bus8.a_in  = x_a;  assign bus8.b_in  = x_b;
  assign bus8.qinv       = x_q;      assign bus8.out_ready = x_oready;
  assign bus32.in_valid  = x_valid;  assign bus32.a_in = x_a;  assign bus32.b_in = x_b;
  assign bus32.qinv      = x_q;      assign bus32.out_ready = x_oready;
  assign bus64.in_valid  = x_valid;  assign bus64.a_in = x_a;  assign bus64.b_in = x_b;
  assign bus64.qinv      = x_q;      assign bus64.out_ready = x_oready;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];
  logic [63:0]  exp_a_q[$];

  localparam logic [127:0] WRAP_EXP = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_job(input logic [63:0] a, input logic [63:0] b, input logic [127:0] q);
    bus.in_valid = 1'b1;
    bus.a_in     = a;
    bus.b_in     = b;
    bus.qinv     = q;
  endtask

  task automatic scramble_inputs();
    bus.in_valid = 1'b0;
    bus.a_in     = {$urandom, $urandom};
    bus.b_in     = {$urandom, $urandom};
    bus.qinv     = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Waits up to max_cyc edges for out_valid; an expired budget counts as a failure.
  task automatic wait_out(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    if (bus.out_valid !== 1'b1) check({tag, "_timeout"}, 128'(bus.out_valid), 128'd1);
  endtask

  // Single job with out_ready=1, result compared against a hand-computed value.
  task automatic run_job(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [127:0] q, input logic [127:0] exp_bq);
    bus.out_ready = 1'b1;
    drive_job(a, b, q);
    tick();
    scramble_inputs();
    wait_out(10, tag);
    check({tag, "_bq"}, bus.bq_out, exp_bq);
    check({tag, "_a"},  128'(bus.a_out), 128'(a));
    tick();
  endtask

  int lat16, lat8, lat32, lat64;
  logic [127:0] hold_bq;
  logic [127:0] rq;
  logic [63:0]  ra, rb;

  initial begin
    bus.in_valid = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.qinv = '0; bus.out_ready = 1'b1;
    x_valid = 1'b0; x_a = '0; x_b = '0; x_q = '0; x_oready = 1'b1;

    // Reset state
    rst = 1'b0;
    tick(); tick();
    check("rst_in_ready",  128'(bus.in_ready),  128'd1);
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_a_out",     128'(bus.a_out),     128'd0);
    check("rst_bq_out",    bus.bq_out,          128'd0);
    check("rst_state",     128'(st16),          128'd0);
    rst = 1'b1;
    tick();

    // Basic: latency 4, in_ready low for 5 cycles after acceptance
    drive_job(64'h7, 64'h1, 128'h5);
    tick();
    scramble_inputs();
    check("basic_ready_c0", 128'(bus.in_ready), 128'd0);
    check("basic_valid_c0", 128'(bus.out_valid), 128'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("basic_ready_c%0d", k), 128'(bus.in_ready), 128'd0);
      check($sformatf("basic_valid_c%0d", k), 128'(bus.out_valid), (k == 4) ? 128'd1 : 128'd0);
    end
    check("basic_bq", bus.bq_out, 128'h5);
    check("basic_a",  128'(bus.a_out), 128'h7);
    tick();
    check("basic_drain_valid", 128'(bus.out_valid), 128'd0);
    check("basic_drain_ready", 128'(bus.in_ready),  128'd1);
    check("basic_hold_bq",     bus.bq_out,          128'h5);

    // Wrap-around on all four digit widths at once
    drive_job(64'h1, 64'hFFFF_FFFF_FFFF_FFFF, {128{1'b1}});
    x_valid = 1'b1; x_a = 64'h1; x_b = 64'hFFFF_FFFF_FFFF_FFFF; x_q = {128{1'b1}};
    tick();
    scramble_inputs();
    x_valid = 1'b0; x_b = '0; x_q = '0;
    lat16 = -1; lat8 = -1; lat32 = -1; lat64 = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (lat16 < 0 && bus.out_valid)   lat16 = k;
      if (lat8  < 0 && bus8.out_valid)  lat8  = k;
      if (lat32 < 0 && bus32.out_valid) lat32 = k;
      if (lat64 < 0 && bus64.out_valid) lat64 = k;
    end
    check("wrap_lat16", 128'(lat16), 128'd4);
    check("wrap_lat8",  128'(lat8),  128'd8);
    check("wrap_lat32", 128'(lat32), 128'd2);
    check("wrap_lat64", 128'(lat64), 128'd1);
    check("wrap_bq16",  bus.bq_out,   WRAP_EXP);
    check("wrap_bq8",   bus8.bq_out,  WRAP_EXP);
    check("wrap_bq32",  bus32.bq_out, WRAP_EXP);
    check("wrap_bq64",  bus64.bq_out, WRAP_EXP);
    tick();

    // Backpressure: result held for 10 cycles while a new job is offered
    bus.out_ready = 1'b0;
    drive_job(64'h1234, 64'h10, 128'h3);
    tick();
    scramble_inputs();
    wait_out(10, "bp_first");
    drive_job(64'hAA, 64'h2, 128'h100);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("bp_valid_%0d", k), 128'(bus.out_valid), 128'd1);
      check($sformatf("bp_bq_%0d", k),    bus.bq_out,           128'h30);
      check($sformatf("bp_a_%0d", k),     128'(bus.a_out),      128'h1234);
      check($sformatf("bp_ready_%0d", k), 128'(bus.in_ready),   128'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_drain_valid", 128'(bus.out_valid), 128'd0);
    check("bp_drain_ready", 128'(bus.in_ready),  128'd1);
    check("bp_drain_state", 128'(st16),          128'd0);
    tick();
    check("bp_accept_ready", 128'(bus.in_ready), 128'd0);
    check("bp_accept_state", 128'(st16),         128'd1);
    scramble_inputs();
    wait_out(10, "bp_second");
    check("bp_second_bq", bus.bq_out,      128'h200);
    check("bp_second_a",  128'(bus.a_out), 128'hAA);
    tick();

    // Reset mid-MUL at cnt==2, then a normal job
    drive_job(64'h99, 64'hFFFF_0000_1234_5678, 128'h7);
    tick();
    scramble_inputs();
    tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_rst_valid", 128'(bus.out_valid), 128'd0);
    check("mid_rst_bq",    bus.bq_out,          128'd0);
    check("mid_rst_ready", 128'(bus.in_ready),  128'd1);
    check("mid_rst_a",     128'(bus.a_out),     128'd0);
    drive_job(64'h55, 64'h3, 128'h10);
    tick();
    scramble_inputs();
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("post_rst_valid_c%0d", k), 128'(bus.out_valid), (k == 4) ? 128'd1 : 128'd0);
    end
    check("post_rst_bq", bus.bq_out,      128'h30);
    check("post_rst_a",  128'(bus.a_out), 128'h55);
    tick();

    // Edge operands and digit-placement vectors
    run_job("b_zero",  64'h1, 64'h0, 128'hDEAD_BEEF_0000_0001, 128'h0);
    run_job("nonzero", 64'h2, 64'h0001_0002_0003_0004, 128'h10, 128'h0010_0020_0030_0040);
    run_job("q_zero",  64'h3, 64'hFFFF_FFFF_FFFF_FFFF, 128'h0, 128'h0);
    run_job("trunc",   64'h4, 64'h1_0000, {1'b1, 126'b0, 1'b1}, 128'h1_0000);

    // in_valid during MUL is ignored
    drive_job(64'h66, 64'h5, 128'h7);
    tick();
    drive_job(64'h77, 64'h9, 128'h9);
    tick(); tick();
    scramble_inputs();
    wait_out(10, "ignore");
    check("ignore_bq", bus.bq_out,      128'h23);
    check("ignore_a",  128'(bus.a_out), 128'h66);
    tick();

    // Random jobs with random stalls against a 128-bit reference product
    for (int j = 0; j < 200; j++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rq = {$urandom, $urandom, $urandom, $urandom};
      if (j % 17 == 0) rb = 64'hFFFF_FFFF_FFFF_FFFF;
      exp_q.push_back(128'({64'b0, rb} * rq));
      exp_a_q.push_back(ra);
      bus.out_ready = 1'b0;
      drive_job(ra, rb, rq);
      tick();
      scramble_inputs();
      wait_out(10, "rand");
      hold_bq = bus.bq_out;
      for (int s = $urandom_range(0, 3); s > 0; s--) tick();
      check("rand_hold", bus.bq_out, hold_bq);
      check("rand_bq", bus.bq_out, exp_q.pop_front());
      check("rand_a",  128'(bus.a_out), 128'(exp_a_q.pop_front()));
      bus.out_ready = 1'b1;
      tick();
    end
    check("rand_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
